// File: rtl/x_pkg.sv
// Shared switch-fabric definitions: packet widths, field offsets
// and the VC index type used by initiator and target units.
package x_pkg;

    localparam int VCN_DFLT = 2;

    typedef logic [$clog2(VCN_DFLT)-1:0] vc_idx_t;

    // Request: {dst, src, wr, vc, adr, stb, dat, sb}
    function automatic int tp_w(
        int n, int m, int vcb, int a, int d, int sb
    );
        return m + n + 1 + vcb + a + d / 8 + d + sb;
    endfunction

    // Response: {dst, src, vc, dat, rsb}
    function automatic int rp_w(
        int n, int m, int vcb, int d, int rsb
    );
        return n + m + vcb + d + rsb;
    endfunction

    function automatic int rp_dat_lsb(int rsb);
        return rsb;
    endfunction

    function automatic int rp_vc_lsb(int d, int rsb);
        return rsb + d;
    endfunction

    function automatic int rp_src_lsb(int vcb, int d, int rsb);
        return rsb + d + vcb;
    endfunction

    function automatic int rp_dst_lsb(
        int m, int vcb, int d, int rsb
    );
        return rsb + d + vcb + m;
    endfunction

endpackage

// File: rtl/x_init_unit_if.sv
// Master-side and switch-side handshake bundle of the
// initiator unit.
interface x_init_unit_if
    import x_pkg::*;
#(
    parameter int N   = 2,
    parameter int M   = 3,
    parameter int A   = 19,
    parameter int D   = 32,
    parameter int DA  = 32,
    parameter int VCN = 2,
    parameter int SB  = 4,
    parameter int RSB = 2
);
    localparam int VCB = $clog2(VCN);
    localparam int TP  = tp_w(N, M, VCB, A, D, SB);
    localparam int RP  = rp_w(N, M, VCB, D, RSB);

    logic             m_req_vld;
    logic             m_req_gnt;
    logic [VCB-1:0]   m_req_vc;
    logic             m_req_wr;
    logic [DA-1:0]    m_req_adr;
    logic [D/8-1:0]   m_req_stb;
    logic [D-1:0]     m_req_dat;
    logic [SB-1:0]    m_req_sb;

    logic             i_vld;
    logic             i_gnt;
    logic [TP-1:0]    i_pld;

    logic             r_vld;
    logic             r_gnt;
    logic [RP-1:0]    r_pld;

    logic             m_rsp_vld;
    logic             m_rsp_gnt;
    logic [VCB-1:0]   m_rsp_vc;
    logic [M-1:0]     m_rsp_src;
    logic [D-1:0]     m_rsp_dat;
    logic [RSB-1:0]   m_rsp_sb;

    modport slave (
        input  m_req_vld, m_req_vc, m_req_wr, m_req_adr,
        input  m_req_stb, m_req_dat, m_req_sb,
        input  i_gnt, r_vld, r_pld, m_rsp_gnt,
        output m_req_gnt, i_vld, i_pld, r_gnt,
        output m_rsp_vld, m_rsp_vc, m_rsp_src,
        output m_rsp_dat, m_rsp_sb
    );

    modport master (
        output m_req_vld, m_req_vc, m_req_wr, m_req_adr,
        output m_req_stb, m_req_dat, m_req_sb,
        output i_gnt, r_vld, r_pld, m_rsp_gnt,
        input  m_req_gnt, i_vld, i_pld, r_gnt,
        input  m_rsp_vld, m_rsp_vc, m_rsp_src,
        input  m_rsp_dat, m_rsp_sb
    );

endinterface

// File: rtl/x_reg_slice.sv
// One-entry full-throughput register slice; the payload only
// loads when empty or draining, so it holds while stalled.
module x_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [W-1:0] up_dat,
    output logic         dn_vld,
    input  logic         dn_rdy,
    output logic [W-1:0] dn_dat
);

    logic         vld;
    logic [W-1:0] dat;

    assign up_rdy = !vld || dn_rdy;
    assign dn_vld = vld;
    assign dn_dat = dat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (up_rdy) begin
            vld <= up_vld;
            if (up_vld) begin
                dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/x_init_unit.sv
// Initiator endpoint: packs master requests into switch packets,
// unpacks responses and limits outstanding transactions per VC.
module x_init_unit
    import x_pkg::*;
#(
    parameter int N   = 2,
    parameter int M   = 3,
    parameter int A   = 19,
    parameter int D   = 32,
    parameter int DA  = 32,
    parameter int VCN = 2,
    parameter int SB  = 4,
    parameter int RSB = 2,
    parameter int OT  = 4,
    parameter int ID  = 0
) (
    input  logic clk,
    input  logic rstn,
    x_init_unit_if.slave bus
);

    localparam int VCB = $clog2(VCN);
    localparam int TP  = tp_w(N, M, VCB, A, D, SB);
    localparam int RP  = rp_w(N, M, VCB, D, RSB);
    localparam int CW  = $clog2(OT + 1);
    localparam int RW  = RP - N;

    localparam int DAT_LSB = rp_dat_lsb(RSB);
    localparam int VC_LSB  = rp_vc_lsb(D, RSB);
    localparam int SRC_LSB = rp_src_lsb(VCB, D, RSB);

    logic [CW-1:0]  cnt [VCN];
    logic [VCN-1:0] inc;
    logic [VCN-1:0] dec;

    logic           rq_rdy;
    logic           req_acc;
    logic           rsp_hs;
    logic           has_credit;
    logic [M-1:0]   dst;
    logic [N-1:0]   src;
    logic [TP-1:0]  rq_pld;
    logic [RW-1:0]  rs_in;
    logic [RW-1:0]  rs_out;
    logic           unused_adr;

    assign dst = bus.m_req_adr[DA-1 -: M];
    assign src = N'(ID);
    assign unused_adr = ^bus.m_req_adr[DA-M-1:A];

    assign has_credit    = cnt[bus.m_req_vc] < CW'(OT);
    assign bus.m_req_gnt = rq_rdy && has_credit;
    assign req_acc       = bus.m_req_vld && bus.m_req_gnt;
    assign rsp_hs        = bus.m_rsp_vld && bus.m_rsp_gnt;

    assign rq_pld = {
        dst, src, bus.m_req_wr, bus.m_req_vc,
        bus.m_req_adr[A-1:0], bus.m_req_stb,
        bus.m_req_dat, bus.m_req_sb
    };

    x_reg_slice #(.W(TP)) u_req (
        .clk    (clk),
        .rstn   (rstn),
        .up_vld (req_acc),
        .up_rdy (rq_rdy),
        .up_dat (rq_pld),
        .dn_vld (bus.i_vld),
        .dn_rdy (bus.i_gnt),
        .dn_dat (bus.i_pld)
    );

    // The destination field is ours by construction; drop it.
    assign rs_in = bus.r_pld[RW-1:0];

    x_reg_slice #(.W(RW)) u_rsp (
        .clk    (clk),
        .rstn   (rstn),
        .up_vld (bus.r_vld),
        .up_rdy (bus.r_gnt),
        .up_dat (rs_in),
        .dn_vld (bus.m_rsp_vld),
        .dn_rdy (bus.m_rsp_gnt),
        .dn_dat (rs_out)
    );

    assign bus.m_rsp_src = rs_out[SRC_LSB +: M];
    assign bus.m_rsp_vc  = rs_out[VC_LSB +: VCB];
    assign bus.m_rsp_dat = rs_out[DAT_LSB +: D];
    assign bus.m_rsp_sb  = rs_out[RSB-1:0];

    always_comb begin
        inc = '0;
        dec = '0;
        inc[bus.m_req_vc] = req_acc;
        dec[bus.m_rsp_vc] = rsp_hs;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < VCN; v++) begin
                cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VCN; v++) begin
                if (inc[v] && !dec[v]) begin
                    cnt[v] <= cnt[v] + CW'(1);
                end else if (dec[v] && !inc[v]) begin
                    cnt[v] <= cnt[v] - CW'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn) begin
            if (bus.r_vld) begin
                assert (bus.r_pld[RP-1 -: N] == N'(ID))
                else $error("response routed to wrong initiator");
            end
            if (rsp_hs) begin
                assert (cnt[bus.m_rsp_vc] != '0)
                else $error("response without outstanding request");
            end
            for (int v = 0; v < VCN; v++) begin
                assert (cnt[v] <= CW'(OT))
                else $error("credit counter overflow");
            end
        end
    end
`endif

endmodule
